// File: rtl/looper_pkg.sv
// Shared mode encodings, button bit positions and a constant clog2 helper for the Looper controller.
// Pure declarations: no logic, no latency, no flow control.
package looper_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RECORD = 2'd1,
    MODE_PLAY   = 2'd2,
    MODE_CLEAR  = 2'd3
  } mode_e;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/looper_ctrl_if.sv
// Button/memory-side bundle of the Looper controller; master is the controller, slave the
// button front end plus memory controller. Levels only, no handshake beyond clear_req/clear_ack.
interface looper_ctrl_if #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2
);
  logic [4:0]           btn;
  logic                 mem_full;
  logic                 clear_ack;
  logic [1:0]           mode;
  logic [BANK_W-1:0]    bank;
  logic                 rec_en;
  logic                 play_en;
  logic                 start;
  logic                 clear_req;
  logic [NUM_BANKS-1:0] has_data;

  modport master (
    input  btn, mem_full, clear_ack,
    output mode, bank, rec_en, play_en, start, clear_req, has_data
  );

  modport slave (
    output btn, mem_full, clear_ack,
    input  mode, bank, rec_en, play_en, start, clear_req, has_data
  );
endinterface

// File: rtl/looper_ctrl_press_classifier.sv
// Center-button hold timer: SHORT on release before LONG_TICKS, LONG once while still held.
// Events are combinational from registered count/arm state; one-cycle pulses, no backpressure.
module press_classifier
  import looper_pkg::*;
#(
  parameter int LONG_TICKS = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic rise_i,
  input  logic fall_i,
  output logic short_o,
  output logic long_o
);

  localparam int CW = clog2(LONG_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  assign long_o  = armed_q & btn_i & ~rise_i & (cnt_q == CW'(LONG_TICKS - 1));
  assign short_o = armed_q & fall_i;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (rise_i) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (long_o || short_o) begin
      // Disarming here is what suppresses a SHORT after a LONG on release
      armed_d = 1'b0;
    end else if (armed_q && btn_i && (cnt_q < CW'(LONG_TICKS))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/looper_ctrl.sv
// Looper mode/bank FSM: button edges and center hold events select IDLE/RECORD/PLAY/CLEAR.
// All outputs come from registers (one-clock latency); CLEAR waits indefinitely for clear_ack.
module looper_ctrl
  import looper_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_W     = 2,
  parameter int LONG_TICKS = 100_000_000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  looper_ctrl_if.master bus
);

  logic [4:0]           btn_q;
  logic [4:0]           rise;
  logic                 fall_c;
  logic                 short_ev, long_ev;

  mode_e                mode_q, mode_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [NUM_BANKS-1:0] has_data_q, has_data_d;
  logic                 start_q, start_d;

  assign rise   = bus.btn & ~btn_q;
  assign fall_c = ~bus.btn[BTN_C] & btn_q[BTN_C];

  press_classifier #(.LONG_TICKS(LONG_TICKS)) u_press (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (bus.btn[BTN_C]),
    .rise_i  (rise[BTN_C]),
    .fall_i  (fall_c),
    .short_o (short_ev),
    .long_o  (long_ev)
  );

  // Each if/else chain below follows the global event priority, restricted to the events the state uses
  always_comb begin
    mode_d     = mode_q;
    bank_d     = bank_q;
    has_data_d = has_data_q;
    start_d    = 1'b0;
    case (mode_q)
      MODE_IDLE: begin
        if (long_ev) begin
          mode_d = MODE_CLEAR;
        end else if (short_ev) begin
          mode_d  = MODE_RECORD;
          start_d = 1'b1;
        end else if (rise[BTN_U] && has_data_q[bank_q]) begin
          mode_d  = MODE_PLAY;
          start_d = 1'b1;
        end else if (rise[BTN_L]) begin
          bank_d = (bank_q == '0) ? BANK_W'(NUM_BANKS - 1) : bank_q - BANK_W'(1);
        end else if (rise[BTN_R]) begin
          bank_d = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + BANK_W'(1);
        end
      end
      MODE_RECORD: begin
        // Holding off during the entry cycle keeps start from pulsing twice in a row
        if (!start_q && (bus.mem_full || rise[BTN_D] || short_ev)) begin
          mode_d             = MODE_PLAY;
          start_d            = 1'b1;
          has_data_d[bank_q] = 1'b1;
        end
      end
      MODE_PLAY: begin
        if (rise[BTN_D] || short_ev) begin
          mode_d = MODE_IDLE;
        end
      end
      MODE_CLEAR: begin
        if (bus.clear_ack) begin
          has_data_d[bank_q] = 1'b0;
          mode_d             = MODE_IDLE;
        end
      end
      default: mode_d = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q      <= '0;
      mode_q     <= MODE_IDLE;
      bank_q     <= '0;
      has_data_q <= '0;
      start_q    <= 1'b0;
    end else begin
      btn_q      <= bus.btn;
      mode_q     <= mode_d;
      bank_q     <= bank_d;
      has_data_q <= has_data_d;
      start_q    <= start_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.bank      = bank_q;
  assign bus.has_data  = has_data_q;
  assign bus.start     = start_q;
  assign bus.rec_en    = (mode_q == MODE_RECORD);
  assign bus.play_en   = (mode_q == MODE_PLAY);
  assign bus.clear_req = (mode_q == MODE_CLEAR);

endmodule

// File: tb/tb_looper_ctrl.sv
// Directed bench for looper_ctrl with LONG_TICKS=8, four banks.
module tb_looper_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  looper_ctrl_if #(.NUM_BANKS(4), .BANK_W(2)) bus ();

  looper_ctrl #(.NUM_BANKS(4), .BANK_W(2), .LONG_TICKS(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int bank_seq [7];
  int starts;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n         = 1'b0;
    bus.btn       = '0;
    bus.mem_full  = 1'b0;
    bus.clear_ack = 1'b0;
    tick(3);
    check("rst_mode",     bus.mode, 0);
    check("rst_bank",     bus.bank, 0);
    check("rst_has_data", bus.has_data, 0);
    check("rst_start",    bus.start, 0);
    check("rst_rec_en",   bus.rec_en, 0);
    check("rst_play_en",  bus.play_en, 0);
    check("rst_clear_req", bus.clear_req, 0);
    rst_n = 1'b1;
    tick(1);

    // bank stepping: right x5 then left x2
    bank_seq = '{1, 2, 3, 0, 1, 0, 3};
    for (int i = 0; i < 7; i++) begin
      bus.btn[(i < 5) ? 3 : 2] = 1'b1;
      tick(1);
      check($sformatf("bank_step%0d", i), bus.bank, bank_seq[i]);
      bus.btn = '0;
      tick(1);
    end
    check("bank_has_data", bus.has_data, 0);

    // short press -> RECORD
    bus.btn[0] = 1'b1;
    tick(3);
    check("hold_idle", bus.mode, 0);
    bus.btn[0] = 1'b0;
    tick(1);
    check("rec_mode",  bus.mode, 1);
    check("rec_en",    bus.rec_en, 1);
    check("rec_start", bus.start, 1);
    tick(1);
    check("rec_start_drop", bus.start, 0);
    tick(2);
    // tap -> PLAY with data on bank 3
    bus.btn[0] = 1'b1;
    tick(1);
    bus.btn[0] = 1'b0;
    tick(1);
    check("play_mode",     bus.mode, 2);
    check("play_en",       bus.play_en, 1);
    check("play_start",    bus.start, 1);
    check("play_has_data", bus.has_data, 4'b1000);
    tick(1);
    check("play_start_drop", bus.start, 0);
    bus.btn[4] = 1'b1;
    tick(1);
    check("down_idle", bus.mode, 0);
    bus.btn = '0;
    tick(1);

    // up on empty bank 0 is ignored
    bus.btn[3] = 1'b1;
    tick(1);
    bus.btn = '0;
    tick(1);
    check("wrap_bank0", bus.bank, 0);
    bus.btn[1] = 1'b1;
    tick(1);
    check("up_empty_mode",  bus.mode, 0);
    check("up_empty_start", bus.start, 0);
    bus.btn = '0;
    tick(1);
    bus.btn[2] = 1'b1;
    tick(1);
    bus.btn = '0;
    tick(1);
    check("wrap_bank3", bus.bank, 3);
    bus.btn[1] = 1'b1;
    tick(1);
    check("up_data_mode",  bus.mode, 2);
    check("up_data_start", bus.start, 1);
    bus.btn = '0;
    tick(1);
    bus.btn[4] = 1'b1;
    tick(1);
    bus.btn = '0;
    tick(1);
    check("up_down_idle", bus.mode, 0);

    // long press -> CLEAR on the 9th edge after the press
    bus.btn[0] = 1'b1;
    tick(8);
    check("long_not_yet", bus.mode, 0);
    tick(1);
    check("long_clear",     bus.mode, 3);
    check("long_clear_req", bus.clear_req, 1);
    tick(5);
    bus.btn[3] = 1'b1;
    tick(1);
    check("clear_bank_frozen", bus.bank, 3);
    bus.btn[3] = 1'b0;
    tick(5);
    bus.btn[0] = 1'b0;
    tick(1);
    check("release_no_short", bus.mode, 3);
    tick(4);
    bus.clear_ack = 1'b1;
    tick(1);
    bus.clear_ack = 1'b0;
    check("ack_idle",      bus.mode, 0);
    check("ack_has_data",  bus.has_data, 0);
    check("ack_clear_req", bus.clear_req, 0);

    // mem_full coincident with a center release in RECORD
    bus.btn[0] = 1'b1;
    tick(1);
    bus.btn[0] = 1'b0;
    tick(1);
    check("mf_rec", bus.mode, 1);
    tick(2);
    bus.btn[0] = 1'b1;
    tick(2);
    bus.btn[0]   = 1'b0;
    bus.mem_full = 1'b1;
    tick(1);
    check("mf_play", bus.mode, 2);
    starts = int'(bus.start);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      starts += int'(bus.start);
    end
    check("mf_one_start",  starts, 1);
    check("mf_play_stays", bus.mode, 2);
    check("mf_has_data",   bus.has_data, 4'b1000);
    bus.mem_full = 1'b0;

    // reset in the middle of CLEAR
    bus.btn[4] = 1'b1;
    tick(1);
    bus.btn = '0;
    tick(1);
    check("pre_clear_idle", bus.mode, 0);
    bus.btn[0] = 1'b1;
    tick(9);
    check("pre_rst_clear_req", bus.clear_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_req", bus.clear_req, 0);
    check("async_mode",      bus.mode, 0);
    bus.btn = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_mode",     bus.mode, 0);
    check("post_rst_bank",     bus.bank, 0);
    check("post_rst_has_data", bus.has_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
